seq_signed_divider: RTL and testbench
=====================================

# seq_signed_divider

Multi-cycle signed 64÷32 divider: the inverse of the team's 32×32 signed multiplier. It accepts a 64-bit signed dividend, such as a multiplier product, and a 32-bit signed divisor. It returns a 32-bit quotient and remainder with truncation toward zero. It sits beside the multiplier in the arithmetic datapath and uses the same `start`-pulse / fixed-latency style, plus an explicit `done`/`busy` handshake.

## Interface
Parameters:
- none (widths fixed at 64/32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  64  signed dividend; sampled on the accepting edge
- divisor  input  32  signed divisor; sampled on the accepting edge
- quotient  output  32  signed quotient, registered
- remainder  output  32  signed remainder, registered
- done  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight
- div_by_zero  output  1  divisor was 0 (valid with/after done)
- overflow  output  1  true quotient outside signed 32-bit range

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values: quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, overflow=0, FSM=IDLE, iteration counter=0.
- FSM states and transitions:
  - IDLE: `start`=1 latches the operands -> PREP.
  - PREP: stores |dividend| (64-bit unsigned; 2^63 is legal) and |divisor| (32-bit unsigned; 2^31 is legal). Latches both operand signs. If divisor==0 -> FIX, else -> DIV with counter=0.
  - DIV: 64 iterations of non-restoring-free (restoring) shift/subtract, one per cycle. The partial remainder register is 33 bits wide. Each iteration yields one quotient bit into a 64-bit magnitude register. After iteration 63 -> FIX.
  - FIX: applies signs and writes the outputs; done=1 -> IDLE.
- Sign rules:
  - Quotient is negative iff the operand signs differ (and the magnitude is nonzero).
  - Remainder takes the dividend's sign.
  - Invariant: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.
- Overflow: the signed quotient must lie in [-2^31, 2^31-1]. Otherwise:
  - overflow=1, remainder=0.
  - quotient saturates to 32'h7FFFFFFF if positive, 32'h80000000 if negative.
- Divide by zero:
  - div_by_zero=1, overflow=0.
  - quotient=32'hFFFFFFFF, remainder=dividend[31:0].
- Outputs and flags hold their values until the next FIX write or reset. Flags are cleared or set on every FIX write.
- `start` while busy=1 is ignored. It does not queue.
- rst_n low mid-operation:
  - All outputs and state return to reset values immediately (asynchronous).
  - No done is produced for the aborted operation.

## Timing
- E0 = the edge sampling start=1 in IDLE.
- Normal path:
  - E1 -> DIV.
  - E65 -> FIX.
  - At E66, outputs and flags update and done rises.
  - Latency is 66 cycles.
- Divide-by-zero path: E1 -> FIX; outputs and done at E2. Latency is 2 cycles.
- busy rises at E0 and falls on the same edge that raises done.
- done is high for exactly one cycle and falls on the next edge.
- A start held high on the done edge is not accepted, because the FSM is not yet in IDLE. A start sampled on the following edge is accepted, so back-to-back throughput is 1 operation per 67 cycles.
- Operand inputs may change freely after E0.

## Test plan
- Exact positive division: dividend 64'h1BB6BAA0, divisor 32'h348 -> quotient 32'h00087234, remainder 0, flags 0. done is exactly 66 cycles after E0; busy is high throughout.
- Mixed signs with remainder:
  - dividend 64'hFFFFFFFFF7747564, divisor 32'hFFFFFEFD -> quotient 32'h00087234, remainder 0.
  - dividend -7, divisor 2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF.
  - dividend 7, divisor -2 -> quotient 32'hFFFFFFFD, remainder 1.
- Overflow and range boundaries:
  - dividend 64'h193DE4CED7437964, divisor 1 -> overflow=1, quotient 32'h7FFFFFFF, remainder 0.
  - dividend 64'h8000000000000000, divisor -1 -> overflow=1, quotient 32'h7FFFFFFF.
  - dividend 64'hFFFFFFFF80000000, divisor 1 -> quotient 32'h80000000, overflow=0.
- Divide by zero: dividend 64'h50647236, divisor 0 -> done at E2, div_by_zero=1, quotient 32'hFFFFFFFF, remainder 32'h50647236.
- Handshake:
  - A second start pulse at cycle 20 while busy is ignored. Result matches the first operands, with a single done.
  - Outputs hold after done until the next completion.
- Reset mid-operation:
  - rst_n=0 at cycle 30 -> all outputs 0 and busy 0 immediately, with no done.
  - After release, dividend 0 / divisor 32'hB887CAAF -> quotient 0, remainder 0 in 66 cycles.

Source files
------------

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed 64/32 divider: restoring shift/subtract on magnitudes, signs fixed up at the end.
// Quotient and remainder truncate toward zero; overflow saturates, divide-by-zero returns all-ones.
module seq_signed_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [63:0] work_q, work_d;
  logic [32:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] quot_out_q, quot_out_d;
  logic [31:0] rem_out_q, rem_out_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  logic [33:0] shifted;
  logic        ge;
  logic [32:0] diff;
  assign shifted = {rem_q, work_q[63]};
  assign ge      = shifted >= {2'b00, dvs_q};
  assign diff    = shifted[32:0] - {1'b0, dvs_q};

  logic        q_neg;
  logic        q_ovf;
  logic [31:0] q_val;
  logic [31:0] r_val;
  assign q_neg = (sign_a_q ^ sign_b_q) && (work_q != 64'd0);
  assign q_ovf = q_neg ? (work_q > 64'h0000_0000_8000_0000) : (work_q > 64'h0000_0000_7FFF_FFFF);
  assign q_val = q_neg ? (32'd0 - work_q[31:0]) : work_q[31:0];
  assign r_val = sign_a_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    work_d     = work_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = PREP;
        end
      end
      PREP: begin
        sign_a_d = dvd_q[63];
        sign_b_d = dvs_q[31];
        work_d   = dvd_q[63] ? (64'd0 - dvd_q) : dvd_q;
        dvs_d    = dvs_q[31] ? (32'd0 - dvs_q) : dvs_q;
        rem_d    = 33'd0;
        cnt_d    = 6'd0;
        state_d  = (dvs_q == 32'd0) ? FIX : DIV;
      end
      DIV: begin
        rem_d  = ge ? diff : shifted[32:0];
        work_d = {work_q[62:0], ge};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dvs_q == 32'd0) begin
          dbz_d      = 1'b1;
          ovf_d      = 1'b0;
          quot_out_d = 32'hFFFF_FFFF;
          rem_out_d  = dvd_q[31:0];
        end else if (q_ovf) begin
          dbz_d      = 1'b0;
          ovf_d      = 1'b1;
          quot_out_d = q_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
          rem_out_d  = 32'd0;
        end else begin
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          quot_out_d = q_val;
          rem_out_d  = r_val;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dvd_q      <= 64'd0;
      dvs_q      <= 32'd0;
      work_q     <= 64'd0;
      rem_q      <= 33'd0;
      cnt_q      <= 6'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      quot_out_q <= 32'd0;
      rem_out_q  <= 32'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: hand-computed vectors, latency, handshake and reset checks.
// Result vectors are packed as {quotient, remainder, overflow, div_by_zero}.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_signed_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // Launches one operation, scrambles the operand inputs after E0, and waits (bounded) for done.
  task automatic do_op(input logic [63:0] a, input logic [31:0] b, output int lat, output bit busy_ok);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    busy_ok  = (busy === 1'b1);
    lat      = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 64'd0;
    divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, done, busy, div_by_zero, overflow, dbg_state} !== 70'd0) begin
      errors++;
      $display("FAIL reset_state: got q=%h r=%h done=%b busy=%b dbz=%b ovf=%b st=%0d, expected all zero",
               quotient, remainder, done, busy, div_by_zero, overflow, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact();
    int lat;
    bit bok;
    do_op(64'h0000_0000_1BB6_BAA0, 32'h0000_0348, lat, bok);
    checks++;
    if (lat !== 66) begin
      errors++;
      $display("FAIL exact_latency: got %0d, expected 66", lat);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++;
      $display("FAIL exact_busy: busy was not high throughout / low at done");
    end
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== {32'h0008_7234, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exact_result: got q=%h r=%h ovf=%b dbz=%b, expected q=00087234 r=00000000 ovf=0 dbz=0",
               quotient, remainder, overflow, div_by_zero);
    end
  endtask

  task automatic test_mixed_signs();
    logic [63:0] a_t[3];
    logic [31:0] b_t[3];
    logic [65:0] e_t[3];
    int lat;
    bit bok;
    a_t[0] = 64'hFFFF_FFFF_F774_7564; b_t[0] = 32'hFFFF_FEFD; e_t[0] = {32'h0008_7234, 32'h0000_0000, 2'b00};
    a_t[1] = 64'hFFFF_FFFF_FFFF_FFF9; b_t[1] = 32'h0000_0002; e_t[1] = {32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00};
    a_t[2] = 64'h0000_0000_0000_0007; b_t[2] = 32'hFFFF_FFFE; e_t[2] = {32'hFFFF_FFFD, 32'h0000_0001, 2'b00};
    for (int k = 0; k < 3; k++) begin
      do_op(a_t[k], b_t[k], lat, bok);
      checks++;
      if (lat !== 66) begin
        errors++;
        $display("FAIL mixed_latency[%0d]: got %0d, expected 66", k, lat);
      end
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== e_t[k]) begin
        errors++;
        $display("FAIL mixed_result[%0d]: got %h, expected %h", k,
                 {quotient, remainder, overflow, div_by_zero}, e_t[k]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] a_t[3];
    logic [31:0] b_t[3];
    logic [65:0] e_t[3];
    int lat;
    bit bok;
    a_t[0] = 64'h193D_E4CE_D743_7964; b_t[0] = 32'h0000_0001; e_t[0] = {32'h7FFF_FFFF, 32'h0, 2'b10};
    a_t[1] = 64'h8000_0000_0000_0000; b_t[1] = 32'hFFFF_FFFF; e_t[1] = {32'h7FFF_FFFF, 32'h0, 2'b10};
    a_t[2] = 64'hFFFF_FFFF_8000_0000; b_t[2] = 32'h0000_0001; e_t[2] = {32'h8000_0000, 32'h0, 2'b00};
    for (int k = 0; k < 3; k++) begin
      do_op(a_t[k], b_t[k], lat, bok);
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== e_t[k]) begin
        errors++;
        $display("FAIL overflow_result[%0d]: got %h, expected %h (lat %0d)", k,
                 {quotient, remainder, overflow, div_by_zero}, e_t[k], lat);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    bit bok;
    do_op(64'h0000_0000_5064_7236, 32'h0, lat, bok);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL dbz_latency: got %0d, expected 2", lat);
    end
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== {32'hFFFF_FFFF, 32'h5064_7236, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: got q=%h r=%h ovf=%b dbz=%b, expected q=ffffffff r=50647236 ovf=0 dbz=1",
               quotient, remainder, overflow, div_by_zero);
    end
  endtask

  // Called right after a done: done must drop and the results must hold while idle.
  task automatic test_hold();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({done, busy, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 32'hFFFF_FFFF, 32'h5064_7236, 1'b1}) begin
        errors++;
        $display("FAIL hold[%0d]: got done=%b busy=%b q=%h r=%h dbz=%b, expected 0 0 ffffffff 50647236 1",
                 i, done, busy, quotient, remainder, div_by_zero);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int first;
    @(negedge clk);
    dividend = 64'h0000_0000_1BB6_BAA0;
    divisor  = 32'h0000_0348;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    first  = -1;
    for (int i = 1; i <= 120; i++) begin
      if (i == 20) begin
        dividend = 64'd100;
        divisor  = 32'd3;
        start    = 1'b1;
      end
      if (i == 21) start = 1'b0;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (n_done !== 1 || first !== 66) begin
      errors++;
      $display("FAIL ignore_start_done: got %0d dones first at %0d, expected 1 done at 66", n_done, first);
    end
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== {32'h0008_7234, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_start_result: got q=%h r=%h ovf=%b dbz=%b, expected q=00087234 r=0 ovf=0 dbz=0",
               quotient, remainder, overflow, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int d1;
    int d2;
    logic [31:0] q1;
    logic [31:0] r1;
    n  = 0;
    d1 = -1;
    d2 = -1;
    q1 = 32'd0;
    r1 = 32'd0;
    @(negedge clk);
    dividend = 64'hFFFF_FFFF_FFFF_FFF9;
    divisor  = 32'h0000_0002;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 64'h0000_0000_0000_0007;
    divisor  = 32'hFFFF_FFFE;
    for (int i = 1; i <= 200 && n < 2; i++) begin
      @(posedge clk);
      #1;
      if (d1 > 0 && i == d1 + 1) start = 1'b0;
      if (done === 1'b1) begin
        n++;
        if (n == 1) begin
          d1 = i;
          q1 = quotient;
          r1 = remainder;
        end else begin
          d2 = i;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 !== 66 || d2 !== 133) begin
      errors++;
      $display("FAIL b2b_timing: got dones at %0d and %0d, expected 66 and 133", d1, d2);
    end
    checks++;
    if ({q1, r1} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL b2b_first: got q=%h r=%h, expected q=fffffffd r=ffffffff", q1, r1);
    end
    checks++;
    if ({quotient, remainder} !== {32'hFFFF_FFFD, 32'h0000_0001}) begin
      errors++;
      $display("FAIL b2b_second: got q=%h r=%h, expected q=fffffffd r=00000001", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit bok;
    int n_done;
    n_done = 0;
    @(negedge clk);
    dividend = 64'h193D_E4CE_D743_7964;
    divisor  = 32'h0000_0001;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, done, busy, div_by_zero, overflow, dbg_state} !== 70'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got q=%h r=%h done=%b busy=%b dbz=%b ovf=%b st=%0d, expected all zero",
               quotient, remainder, done, busy, div_by_zero, overflow, dbg_state);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, expected 0", n_done);
    end
    do_op(64'd0, 32'hB887_CAAF, lat, bok);
    checks++;
    if (lat !== 66) begin
      errors++;
      $display("FAIL reset_mid_latency: got %0d, expected 66", lat);
    end
    checks++;
    if ({quotient, remainder, overflow, div_by_zero} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid_result: got q=%h r=%h ovf=%b dbz=%b, expected all zero",
               quotient, remainder, overflow, div_by_zero);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_mixed_signs();
    test_overflow();
    test_div_by_zero();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
